// File: rtl/usb_command_decoder.sv
// usb_command_decoder: parses the FT245 byte stream from usb_sequencer into cube commands.
// Latency: every output is registered and appears in the cycle after the accepting strobe edge.
// Backpressure: none. One byte per command_write_enable strobe, and no strobe is ever refused.
//
// Ports:
//   clk, reset_n             clock (rising edge) and asynchronous active-low reset
//   data_in                  byte bus, sampled on edges where command_write_enable=1
//   command_write_enable     one-cycle byte strobe
//   clear_psr                one-cycle acknowledge that clears panel_select_request
//   led_addr/led_data/led_we LED write: 12-bit index, {R,G,B}, and a one-cycle strobe
//   swap_buffers             one-cycle buffer-swap pulse
//   panel_select_request     level flag, set by opcode 0x3 and cleared by clear_psr
//   busy                     a packet is partially received
//   error_count              saturating count of bad opcodes and timeouts
module usb_command_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        command_write_enable,
    input  logic        clear_psr,
    output logic [11:0] led_addr,
    output logic [23:0] led_data,
    output logic        led_we,
    output logic        swap_buffers,
    output logic        panel_select_request,
    output logic        busy,
    output logic [7:0]  error_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        RED,
        GREEN,
        BLUE
    } state_t;

    // The abort fires on the edge where the idle count would reach TIMEOUT_CYCLES.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] timer;
    logic [3:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic [7:0]  red;
    logic [7:0]  green;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            timer                <= 16'd0;
            addr_hi              <= 4'd0;
            addr_lo              <= 8'd0;
            red                  <= 8'd0;
            green                <= 8'd0;
            led_addr             <= 12'd0;
            led_data             <= 24'd0;
            led_we               <= 1'b0;
            swap_buffers         <= 1'b0;
            panel_select_request <= 1'b0;
            busy                 <= 1'b0;
            error_count          <= 8'd0;
        end else begin
            led_we       <= 1'b0;
            swap_buffers <= 1'b0;

            // The acknowledge is applied first so that a 0x3 header on the
            // same edge overrides it and the request stays set.
            if (clear_psr) begin
                panel_select_request <= 1'b0;
            end

            if (command_write_enable) begin
                // An accepted byte always restarts the timer. This also covers
                // a byte that lands on the timeout edge, so the byte wins.
                timer <= 16'd0;
                case (state)
                    IDLE: begin
                        case (data_in[7:4])
                            4'h0: ;
                            4'h1: begin
                                addr_hi <= data_in[3:0];
                                state   <= ADDR_LO;
                                busy    <= 1'b1;
                            end
                            4'h2: swap_buffers <= 1'b1;
                            4'h3: panel_select_request <= 1'b1;
                            default: begin
                                if (error_count != 8'hFF) begin
                                    error_count <= error_count + 8'd1;
                                end
                            end
                        endcase
                    end
                    ADDR_LO: begin
                        addr_lo <= data_in;
                        state   <= RED;
                    end
                    RED: begin
                        red   <= data_in;
                        state <= GREEN;
                    end
                    GREEN: begin
                        green <= data_in;
                        state <= BLUE;
                    end
                    BLUE: begin
                        led_addr <= {addr_hi, addr_lo};
                        led_data <= {red, green, data_in};
                        led_we   <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE) begin
                if (timer == TIMER_LAST) begin
                    // Abort the partial packet. The holding registers keep stale
                    // bytes, but they only reach the outputs after a full packet.
                    state <= IDLE;
                    busy  <= 1'b0;
                    timer <= 16'd0;
                    if (error_count != 8'hFF) begin
                        error_count <= error_count + 8'd1;
                    end
                end else begin
                    timer <= timer + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_command_decoder.sv
module tb_usb_command_decoder;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  data_in;
    logic        command_write_enable;
    logic        clear_psr;
    logic [11:0] led_addr;
    logic [23:0] led_data;
    logic        led_we;
    logic        swap_buffers;
    logic        panel_select_request;
    logic        busy;
    logic [7:0]  error_count;

    usb_command_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .data_in              (data_in),
        .command_write_enable (command_write_enable),
        .clear_psr            (clear_psr),
        .led_addr             (led_addr),
        .led_data             (led_data),
        .led_we               (led_we),
        .swap_buffers         (swap_buffers),
        .panel_select_request (panel_select_request),
        .busy                 (busy),
        .error_count          (error_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the bytes of the packet in progress, and the
    // architecturally visible results.
    logic [7:0]  pkt[$];
    int          since     = 0;
    logic        exp_psr   = 1'b0;
    logic [7:0]  exp_err   = 8'd0;
    logic [11:0] exp_addr  = 12'd0;
    logic [23:0] exp_data  = 24'd0;
    logic        exp_we_now   = 1'b0;
    logic        exp_swap_now = 1'b0;
    int          exp_we_total   = 0;
    int          exp_swap_total = 0;
    int          mon_we   = 0;
    int          mon_swap = 0;

    always @(negedge clk) begin
        if (led_we)       mon_we++;
        if (swap_buffers) mon_swap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".busy"},     64'(busy),                 64'(pkt.size() > 0));
        check({tag, ".psr"},      64'(panel_select_request), 64'(exp_psr));
        check({tag, ".err"},      64'(error_count),          64'(exp_err));
        check({tag, ".led_we"},   64'(led_we),               64'(exp_we_now));
        check({tag, ".swap"},     64'(swap_buffers),         64'(exp_swap_now));
        check({tag, ".led_addr"}, 64'(led_addr),             64'(exp_addr));
        check({tag, ".led_data"}, 64'(led_data),             64'(exp_data));
    endtask

    function automatic void err_inc();
        if (exp_err != 8'd255) exp_err++;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        since = 0;
        if (pkt.size() == 0) begin
            case (b[7:4])
                4'h0: ;
                4'h1: pkt.push_back(b);
                4'h2: begin exp_swap_now = 1'b1; exp_swap_total++; end
                4'h3: exp_psr = 1'b1;
                default: err_inc();
            endcase
        end else begin
            pkt.push_back(b);
            if (pkt.size() == 5) begin
                exp_addr = {pkt[0][3:0], pkt[1]};
                exp_data = {pkt[2], pkt[3], pkt[4]};
                exp_we_now = 1'b1;
                exp_we_total++;
                pkt.delete();
            end
        end
    endfunction

    function automatic void model_reset();
        pkt.delete();
        since    = 0;
        exp_psr  = 1'b0;
        exp_err  = 8'd0;
        exp_addr = 12'd0;
        exp_data = 24'd0;
        exp_we_now   = 1'b0;
        exp_swap_now = 1'b0;
    endfunction

    // Caller is at a falling edge. Returns at the falling edge right after
    // the accepting rising edge.
    task automatic strobe(input logic [7:0] b, input logic clr);
        data_in = b;
        command_write_enable = 1'b1;
        clear_psr = clr;
        @(negedge clk);
        command_write_enable = 1'b0;
        clear_psr = 1'b0;
        data_in = 8'($urandom);
        exp_we_now = 1'b0;
        exp_swap_now = 1'b0;
        if (clr) exp_psr = 1'b0;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_we_now = 1'b0;
            exp_swap_now = 1'b0;
            since++;
            if (pkt.size() > 0 && since >= TO) begin
                pkt.delete();
                err_inc();
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        strobe(b, 1'b0);
        check_state(tag);
        idle(7);
    endtask

    task automatic pulse_clr();
        clear_psr = 1'b1;
        idle(1);
        clear_psr = 1'b0;
        exp_psr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int gap;
        int k;

        reset_n = 1'b0;
        data_in = 8'd0;
        command_write_enable = 1'b0;
        clear_psr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        reset_n = 1'b1;
        idle(3);

        // One LED write packet
        send(8'h1A, "wr1.hdr");
        send(8'h3C, "wr1.lo");
        send(8'hFF, "wr1.r");
        send(8'h80, "wr1.g");
        send(8'h01, "wr1.b");
        check("wr1.addr_const", 64'(led_addr), 64'h0A3C);
        check("wr1.data_const", 64'(led_data), 64'hFF8001);

        // Swap, then the panel request and its acknowledge
        strobe(8'h20, 1'b0);
        check_state("swap.edge");
        idle(1);
        check_state("swap.after");
        idle(6);
        strobe(8'h30, 1'b0);
        check_state("psr.set");
        idle(20);
        check_state("psr.hold");
        pulse_clr();
        check_state("psr.clr");
        idle(7);
        strobe(8'h30, 1'b1);
        check_state("psr.setwins");
        idle(7);
        pulse_clr();
        check_state("psr.clr2");
        pulse_clr();
        check_state("psr.clr_when_0");
        idle(7);

        // Timeout after 0x15, 0x00
        send(8'h15, "to.hdr");
        strobe(8'h00, 1'b0);
        check_state("to.lo");
        idle(TO - 1);
        check_state("to.before");
        idle(1);
        check_state("to.abort");
        check("to.err_const", 64'(error_count), 64'd1);
        idle(7);
        send(8'h10, "wr2.hdr");
        send(8'h05, "wr2.lo");
        send(8'h01, "wr2.r");
        send(8'h02, "wr2.g");
        send(8'h03, "wr2.b");
        check("wr2.addr_const", 64'(led_addr), 64'h005);
        check("wr2.data_const", 64'(led_data), 64'h010203);

        // Byte arriving exactly on the timeout edge
        strobe(8'h1F, 1'b0);
        idle(TO - 1);
        strobe(8'hEE, 1'b0);
        check_state("edge.lo");
        idle(TO - 1);
        strobe(8'h11, 1'b0);
        idle(TO - 1);
        strobe(8'h22, 1'b0);
        idle(TO - 1);
        strobe(8'h33, 1'b0);
        check_state("edge.b");
        idle(7);

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            if (pkt.size() == 0) begin
                k = $urandom_range(0, 7);
                case (k)
                    0:       b = {4'h0, 4'($urandom)};
                    1, 2, 3, 4: b = {4'h1, 4'($urandom)};
                    5:       b = {4'h2, 4'($urandom)};
                    6:       b = {4'h3, 4'($urandom)};
                    default: b = 8'($urandom);
                endcase
            end else begin
                b = 8'($urandom);
            end
            strobe(b, ($urandom_range(0, 7) == 0));
            check_state("rand.byte");
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(7, 12);
            idle(gap);
        end
        idle(TO + 2);
        check_state("rand.end");

        // Reset in the middle of a packet
        send(8'h30, "rst.psr");
        send(8'h12, "rst.hdr");
        send(8'h34, "rst.lo");
        send(8'h56, "rst.r");
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state("rst.async");
        idle(2);
        check_state("rst.held");
        reset_n = 1'b1;
        idle(7);
        send(8'h78, "rst.stale");
        send(8'h1C, "rst2.hdr");
        send(8'hDE, "rst2.lo");
        send(8'hAB, "rst2.r");
        send(8'hCD, "rst2.g");
        send(8'hEF, "rst2.b");
        check("rst2.addr_const", 64'(led_addr), 64'hCDE);
        check("rst2.data_const", 64'(led_data), 64'hABCDEF);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            strobe(8'hF0, 1'b0);
            idle(7);
        end
        check_state("sat");
        check("sat.err_const", 64'(error_count), 64'd255);

        idle(3);
        check("total.led_we", 64'(mon_we), 64'(exp_we_total));
        check("total.swap", 64'(mon_swap), 64'(exp_swap_total));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usb_command_decoder.md
# usb_command_decoder

Consumes the byte stream that `usb_sequencer` reads from the FT245 USB FIFO and turns it into cube commands. Each byte arrives on the shared data bus with a one-cycle `command_write_enable` strobe. The block parses fixed-format packets into:
- LED write strobes (12-bit LED address, 24-bit RGB) for the frame buffer;
- a buffer-swap pulse;
- the `panel_select_request` flag that `usb_sequencer` services and acknowledges via `clear_psr`.

It sits between `usb_sequencer` and the frame-buffer/display logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65535: idle cycles allowed between bytes of a packet before it is aborted; range 1..65535; counter is 16 bits.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  FT245 data bus; valid in any cycle where `command_write_enable`=1.
- `command_write_enable`  in  1  one-cycle byte strobe from `usb_sequencer`; consecutive strobes are ≥8 cycles apart.
- `clear_psr`  in  1  one-cycle acknowledge from `usb_sequencer`; clears `panel_select_request`.
- `led_addr`  out  12  LED index (0..4095), registered.
- `led_data`  out  24  {R,G,B}, registered.
- `led_we`  out  1  one-cycle write strobe; `led_addr`/`led_data` valid while high.
- `swap_buffers`  out  1  one-cycle pulse.
- `panel_select_request`  out  1  level; set by command, cleared by `clear_psr`.
- `busy`  out  1  high while a packet is partially received (state ≠ IDLE).
- `error_count`  out  8  saturating count of protocol errors.

## Operation
- Byte accepted only on a clock edge where `command_write_enable`=1; `data_in` sampled on that edge.
- Header byte: opcode = `data_in[7:4]`, arg = `data_in[3:0]`.
  - 0x0: NOP, stay IDLE.
  - 0x1: LED write; arg = `addr[11:8]`; go to ADDR_LO.
  - 0x2: `swap_buffers`=1 on the next cycle; stay IDLE.
  - 0x3: set `panel_select_request`; stay IDLE.
  - 0x4–0xF: `error_count`+1; stay IDLE.
- FSM states: IDLE → ADDR_LO (captures `addr[7:0]`) → RED → GREEN → BLUE → IDLE. Each transition consumes exactly one accepted byte.
- On the BLUE byte:
  - `led_addr` and `led_data` ({R,G,B}) update;
  - `led_we`=1 for exactly one cycle;
  - FSM returns to IDLE.
- Address and colour bytes are captured into holding registers. `led_addr`/`led_data` change only on the BLUE byte edge and otherwise hold their last value.
- Timeout:
  - counter clears on every accepted byte and counts while state ≠ IDLE;
  - when it reaches `TIMEOUT_CYCLES`: return to IDLE, `error_count`+1, no `led_we`;
  - counter is held at 0 in IDLE.
- `error_count` saturates at 255; no wrap.
- Simultaneous events:
  - `clear_psr` and a 0x3 header on the same edge: the request stays set (set wins).
  - Byte accept and timeout on the same edge: the byte wins, timeout is discarded.
  - Timeout error and unknown-opcode error cannot coincide; the opcode is only decoded in IDLE.
- `clear_psr` while the flag is already 0: no effect.
- A header 0x3 while the flag is already 1: the flag stays 1; the request is not queued twice.
- Reset (asynchronous, any time including mid-packet):
  - state=IDLE, timeout counter=0;
  - `led_addr`=0, `led_data`=0, `led_we`=0, `swap_buffers`=0, `panel_select_request`=0, `busy`=0, `error_count`=0;
  - the partial packet is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from strobe edge to output:
  - `led_we`, `swap_buffers`: high in the cycle immediately after the edge that accepted the BLUE / 0x2 byte, for 1 cycle.
  - `panel_select_request`: rises 1 cycle after the accepting edge.
  - `clear_psr`: `panel_select_request` falls 1 cycle after the acknowledging edge.
- `busy` rises 1 cycle after a 0x1 header and falls 1 cycle after the BLUE byte or a timeout.
- Throughput: one packet per 5 strobes; no back-pressure. The sequencer rate (≥8 cycles/byte) is always sustainable.

## Test plan
- Reset, then send bytes 0x1A, 0x3C, 0xFF, 0x80, 0x01 → one `led_we` pulse with `led_addr`=0xA3C, `led_data`=0xFF8001; `busy` high from after the header until after the BLUE byte; `error_count`=0.
- Send 0x20, then 0x30; assert `clear_psr` 20 cycles later → `swap_buffers` pulses once for 1 cycle; `panel_select_request`=1 from 1 cycle after the 0x30 edge until 1 cycle after `clear_psr`. Repeat with `clear_psr` on the same edge as a 0x30 strobe → flag stays 1.
- With `TIMEOUT_CYCLES`=20, send 0x15, 0x00 and then stop → after 20 idle cycles FSM returns to IDLE, `busy`=0, `error_count`=1, no `led_we`. A following full packet 0x10, 0x05, 0x01, 0x02, 0x03 → `led_addr`=0x005, `led_data`=0x010203.
- Send a byte exactly on the timeout cycle → no abort; packet completes normally.
- Send 300 bytes of 0xF0 → `error_count` saturates at 255; no `led_we` or `swap_buffers` output.
- Assert `reset_n` low mid-packet (after the RED byte), release, then send a full packet → no stale write; all outputs 0 during reset; the new packet decodes correctly.
